miriscv_lsu: RTL and testbench
==============================

Name: miriscv_lsu

Overview:
Load-store unit between the core's execute stage and the data port of the single-port-per-side instruction/data RAM. The RAM data read has one cycle of registered latency. This block does the following:
- turns core load/store requests into word-aligned RAM accesses with byte enables and replicated write data;
- stalls the core across the read latency;
- extracts, sign-extends or zero-extends load data;
- flags misaligned or illegal-size accesses without touching memory.

Parameters:
STORE_STALL, 1, 1: stores also take two cycles (uniform timing); 0: stores complete in the request cycle with no stall.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
lsu_req_i  in  1  core requests a memory access this cycle
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
lsu_addr_i  in  32  byte address
lsu_data_i  in  32  store data (low bits significant)
lsu_data_o  out  32  load result, extended to 32 bits
lsu_stall_req_o  out  1  core must hold the pipeline and its inputs
lsu_fault_o  out  1  misaligned or illegal-size request this cycle
data_req_o  out  1  RAM access strobe
data_we_o  out  1  RAM write enable
data_be_o  out  4  RAM byte enables
data_addr_o  out  32  word-aligned RAM address
data_wdata_o  out  32  RAM write data
data_rdata_i  in  32  RAM read data, valid one cycle after data_req_o

Behaviour:
- FSM states are IDLE and WAIT. Reset forces IDLE and clears the size/offset/we capture registers and the load-hold register to 0.
- Reset values: all outputs are 0 while rst_i is high (combinational outputs gated by reset).
- Offset definition: off = lsu_addr_i[1:0].
- Legal accesses:
  - B/BU: any off.
  - H/HU: off in {0, 2}.
  - W: off = 0.
  - Sizes 011, 110, 111 are illegal.
- IDLE with lsu_req_i = 1 and the access illegal or misaligned:
  - lsu_fault_o = 1 and data_req_o = 0, both combinational.
  - No stall; stay in IDLE.
- IDLE with lsu_req_i = 1 and the access legal:
  - data_req_o = 1 and data_addr_o = {lsu_addr_i[31:2], 2'b00}, combinational, same cycle.
  - data_we_o = lsu_we_i.
  - data_be_o: B = 4'b0001 << off; H = 4'b0011 << off; W = 4'b1111. Stores use these values; for loads data_be_o = 4'b1111.
  - data_wdata_o: B = {4{lsu_data_i[7:0]}}; H = {2{lsu_data_i[15:0]}}; W = lsu_data_i.
  - Capture lsu_size_i, off and lsu_we_i.
  - Load, or store with STORE_STALL = 1: lsu_stall_req_o = 1; next state is WAIT.
  - Store with STORE_STALL = 0: no stall; stay in IDLE.
- WAIT:
  - data_req_o = 0 and lsu_stall_req_o = 0; next state is IDLE unconditionally.
  - lsu_req_i is ignored, because the core still presents the same instruction.
  - Load: lsu_data_o is driven combinationally from data_rdata_i and also latched into the hold register at the clock edge.
  - Byte extract = data_rdata_i[8*off +: 8]. B sign-extends bit 7; BU zero-extends.
  - Half extract = data_rdata_i[8*off +: 16]. H sign-extends bit 15; HU zero-extends.
  - W passes data_rdata_i through.
- Outside a load's WAIT cycle, lsu_data_o shows the hold register (last loaded value, 0 after reset).
- Throughput:
  - One load per 2 cycles.
  - Back-to-back requests are legal: a request in the cycle after WAIT is accepted normally.
- Reset in WAIT: return to IDLE with no data latch; the RAM's returned data is discarded.
- lsu_req_i = 0 in IDLE: all RAM outputs are 0, no stall, no fault.

Test Plan:
- Reset: after rst_i pulse, all outputs = 0 and state IDLE. Then a LW from addr 0x10 with RAM word 0xDEADBEEF:
  - Cycle 0: data_req_o = 1, data_addr_o = 0x10, be = 1111, stall = 1.
  - Cycle 1: lsu_data_o = 0xDEADBEEF, stall = 0.
  - Hold register still 0xDEADBEEF afterwards.
- Byte loads on word 0x80FF7F01:
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
  - LB @0x10 -> 0x00000001.
  - LH @0x12 -> 0xFFFF80FF.
  - LHU @0x12 -> 0x000080FF.
- Stores:
  - SB data 0x000000AB @0x21 -> be = 0010, wdata = 0xABABABAB, addr 0x20, we = 1.
  - SH data 0x1234 @0x22 -> be = 1100, wdata = 0x12341234.
  - Readback LW = 0x1234AB00 from a zeroed word.
- Faults: LW @0x05, LH @0x03, size 011 @0x00 -> each gives fault = 1, data_req_o = 0, no stall, FSM stays IDLE.
- Timing corners:
  - rst_i asserted in the WAIT cycle of LW -> next cycle IDLE, lsu_data_o = 0.
  - Two consecutive LWs (0x0 then 0x4) -> 4 cycles total with correct data each.
  - With STORE_STALL = 0, SW completes with stall = 0 and the next LW is accepted the next cycle.

Source files
------------

// File: rtl/miriscv_lsu.sv
// Load-store unit: maps core load/store requests onto the word-organised data
// RAM port, covers the one-cycle registered read latency with a stall, and
// aligns and extends load data. Misaligned or illegal-size requests raise a
// fault and never reach memory.
module miriscv_lsu #(
    parameter bit STORE_STALL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] hold_q, hold_d;

    logic [1:0]  off;
    logic        legal;
    logic [3:0]  be_store;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_shift;
    logic [31:0] load_ext;

    // Decode the incoming request: legality, store byte enables, replicated data
    always_comb begin
        off       = lsu_addr_i[1:0];
        legal     = 1'b0;
        be_store  = 4'b1111;
        wdata_rep = lsu_data_i;
        case (lsu_size_i)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~off[0];
            3'b010:         legal = (off == 2'b00);
            default:        legal = 1'b0;
        endcase
        case (lsu_size_i[1:0])
            2'b00: begin
                be_store  = 4'b0001 << off;
                wdata_rep = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be_store  = 4'b0011 << off;
                wdata_rep = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be_store  = 4'b1111;
                wdata_rep = lsu_data_i;
            end
        endcase
    end

    // Align returned RAM data to the captured offset and extend per captured size
    always_comb begin
        rdata_shift = data_rdata_i >> {off_q, 3'b000};
        case (size_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b100:  load_ext = {24'h0, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b101:  load_ext = {16'h0, rdata_shift[15:0]};
            default: load_ext = data_rdata_i;
        endcase
    end

    // FSM next state, capture registers and RAM/core outputs (all held at 0 in reset)
    always_comb begin
        state_d         = state_q;
        size_d          = size_q;
        off_d           = off_q;
        we_d            = we_q;
        hold_d          = hold_q;
        lsu_stall_req_o = 1'b0;
        lsu_fault_o     = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'h0;
        data_wdata_o    = 32'h0;
        lsu_data_o      = 32'h0;
        if (!rst_i) begin
            lsu_data_o = hold_q;
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (!legal) begin
                            lsu_fault_o = 1'b1;
                        end else begin
                            data_req_o   = 1'b1;
                            data_we_o    = lsu_we_i;
                            data_addr_o  = {lsu_addr_i[31:2], 2'b00};
                            data_be_o    = lsu_we_i ? be_store : 4'b1111;
                            data_wdata_o = wdata_rep;
                            size_d       = lsu_size_i;
                            off_d        = off;
                            we_d         = lsu_we_i;
                            // Loads always wait for the RAM; stores only when configured to
                            if (!lsu_we_i || STORE_STALL) begin
                                lsu_stall_req_o = 1'b1;
                                state_d         = WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    // The core still presents the stalled instruction, so the request is ignored
                    state_d = IDLE;
                    if (!we_q) begin
                        lsu_data_o = load_ext;
                        hold_d     = load_ext;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and capture registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            size_q  <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            off_q   <= off_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: a driver issues core requests and pushes expected RAM
// requests, load results and faults (from a byte-array memory model) into
// queues; a monitor pops and compares whenever the DUT presents them.
module tb_miriscv_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic        req, we;
    logic [2:0]  size;
    logic [31:0] addr, wdat;
    logic [31:0] ldata, daddr, dwdata, rdata;
    logic        stall, fault, dreq, dwe;
    logic [3:0]  dbe;

    logic        req0, we0;
    logic [2:0]  size0;
    logic [31:0] addr0, wdat0;
    logic [31:0] ldata0, daddr0, dwdata0, rdata0;
    logic        stall0, fault0, dreq0, dwe0;
    logic [3:0]  dbe0;

    miriscv_lsu #(.STORE_STALL(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size),
        .lsu_addr_i(addr), .lsu_data_i(wdat), .lsu_data_o(ldata),
        .lsu_stall_req_o(stall), .lsu_fault_o(fault),
        .data_req_o(dreq), .data_we_o(dwe), .data_be_o(dbe),
        .data_addr_o(daddr), .data_wdata_o(dwdata), .data_rdata_i(rdata)
    );

    miriscv_lsu #(.STORE_STALL(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_i),
        .lsu_req_i(req0), .lsu_we_i(we0), .lsu_size_i(size0),
        .lsu_addr_i(addr0), .lsu_data_i(wdat0), .lsu_data_o(ldata0),
        .lsu_stall_req_o(stall0), .lsu_fault_o(fault0),
        .data_req_o(dreq0), .data_we_o(dwe0), .data_be_o(dbe0),
        .data_addr_o(daddr0), .data_wdata_o(dwdata0), .data_rdata_i(rdata0)
    );

    // RAM models with one cycle of registered read latency
    logic [31:0] ram  [16];
    logic [31:0] ram0 [16];
    always @(posedge clk) begin
        if (dreq) begin
            if (dwe) begin
                for (int i = 0; i < 4; i++)
                    if (dbe[i]) ram[daddr[5:2]][8*i +: 8] <= dwdata[8*i +: 8];
            end else begin
                rdata <= ram[daddr[5:2]];
            end
        end
    end
    always @(posedge clk) begin
        if (dreq0) begin
            if (dwe0) begin
                for (int i = 0; i < 4; i++)
                    if (dbe0[i]) ram0[daddr0[5:2]][8*i +: 8] <= dwdata0[8*i +: 8];
            end else begin
                rdata0 <= ram0[daddr0[5:2]];
            end
        end
    end

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_load_q[$];
    int          exp_fault_q[$];
    logic [7:0]  mref [64];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares DUT activity against the scoreboard queues
    initial begin
        bit          prev_req;
        bit          prev_ld;
        logic [31:0] exp_hold;
        req_t        r;
        logic [31:0] e;
        prev_req = 1'b0;
        prev_ld  = 1'b0;
        exp_hold = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_req = 1'b0;
                prev_ld  = 1'b0;
                exp_hold = 32'h0;
            end else if (mon_en) begin
                if (prev_req) begin
                    chk("wait_req", dreq, 0);
                    chk("wait_stall", stall, 0);
                    chk("wait_fault", fault, 0);
                    if (prev_ld) begin
                        if (exp_load_q.size() == 0) begin
                            chk("unexpected_load", 1, 0);
                        end else begin
                            e = exp_load_q.pop_front();
                            chk("load_data", ldata, e);
                            exp_hold = e;
                        end
                    end
                    prev_req = 1'b0;
                end else begin
                    chk("hold_data", ldata, exp_hold);
                    if (dreq) begin
                        chk("req_stall", stall, 1);
                        chk("req_fault", fault, 0);
                        if (exp_req_q.size() == 0) begin
                            chk("unexpected_req", 1, 0);
                        end else begin
                            r = exp_req_q.pop_front();
                            chk("req_fields", {dwe, dbe, daddr, (dwe ? dwdata : 32'h0)}, r);
                        end
                        prev_req = 1'b1;
                        prev_ld  = !dwe;
                    end else if (fault) begin
                        chk("fault_stall", stall, 0);
                        if (exp_fault_q.size() == 0) chk("unexpected_fault", 1, 0);
                        else void'(exp_fault_q.pop_front());
                    end else begin
                        chk("idle_stall", stall, 0);
                    end
                end
            end
        end
    end

    // One core transaction; called one time unit after a rising edge
    task automatic txn(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        int          n;
        int          off;
        bit          legal;
        logic [31:0] v;
        req_t        r;
        case (sz)
            3'd0, 3'd4: n = 1;
            3'd1, 3'd5: n = 2;
            3'd2:       n = 4;
            default:    n = 0;
        endcase
        off   = int'(a[1:0]);
        legal = (n != 0) && (int'(a[5:0]) % n == 0);
        if (legal) begin
            r.we    = w;
            r.be    = w ? 4'(((1 << n) - 1) << off) : 4'hF;
            r.addr  = {a[31:2], 2'b00};
            r.wdata = !w ? 32'h0 : (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
            exp_req_q.push_back(r);
            if (!w) begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mref[int'(a[5:0]) + i]) << (8 * i));
                if (sz < 3'd4 && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
                exp_load_q.push_back(v);
            end else begin
                for (int i = 0; i < n; i++) mref[int'(a[5:0]) + i] = d[8*i +: 8];
            end
        end else begin
            exp_fault_q.push_back(1);
        end
        $display("[TB] %s size=%0d addr=%h data=%h %s", w ? "ST" : "LD", sz, a, d,
                 legal ? "legal" : "fault");
        req  = 1'b1;
        we   = w;
        size = sz;
        addr = a;
        wdat = d;
        @(posedge clk);
        if (legal) @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Driver: directed scenarios then randomized traffic
    initial begin
        logic [31:0] x;
        int          sz;
        logic [31:0] a;
        rst_i = 1'b1;
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h10; wdat = 32'h0;
        req0 = 1'b1; we0 = 1'b0; size0 = 3'd2; addr0 = 32'h10; wdat0 = 32'h0;
        for (int i = 0; i < 64; i++) mref[i] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset check");
        chk("reset_ctl", {stall, fault, dreq, dwe, dbe}, 0);
        chk("reset_data", {ldata, daddr}, 0);
        chk("reset_wdata", dwdata, 0);
        chk("reset_ctl_ss0", {stall0, fault0, dreq0, dwe0, dbe0}, 0);
        chk("reset_data_ss0", ldata0, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0; req = 1'b0; req0 = 1'b0;
        mon_en = 1'b1;

        // Initialise every RAM word through the unit
        for (int w = 0; w < 16; w++) begin
            x = (w == 4) ? 32'hDEADBEEF : (w == 8) ? 32'h0 : $urandom;
            txn(1'b1, 3'd2, 32'(w * 4), x);
        end
        txn(1'b0, 3'd2, 32'h10, 32'h0);
        idle(3);

        // Byte and half extraction
        txn(1'b1, 3'd2, 32'h10, 32'h80FF7F01);
        txn(1'b0, 3'd0, 32'h13, 32'h0);
        txn(1'b0, 3'd4, 32'h13, 32'h0);
        txn(1'b0, 3'd0, 32'h10, 32'h0);
        txn(1'b0, 3'd1, 32'h12, 32'h0);
        txn(1'b0, 3'd5, 32'h12, 32'h0);

        // Sub-word stores and readback
        txn(1'b1, 3'd0, 32'h21, 32'h000000AB);
        txn(1'b1, 3'd1, 32'h22, 32'h00001234);
        txn(1'b0, 3'd2, 32'h20, 32'h0);

        // Faults, then a request accepted in the very next cycle
        txn(1'b0, 3'd2, 32'h05, 32'h0);
        txn(1'b0, 3'd1, 32'h03, 32'h0);
        txn(1'b0, 3'd3, 32'h00, 32'h0);
        txn(1'b0, 3'd2, 32'h00, 32'h0);
        idle(2);

        // Reset during the WAIT cycle of a load discards the returned data
        $display("[TB] reset during load wait");
        mon_en = 1'b0;
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h10;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_wait_data", ldata, 0);
        chk("rst_wait_stall", stall, 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0; req = 1'b0;
        @(negedge clk);
        chk("rst_wait_hold", ldata, 0);
        chk("rst_wait_req", dreq, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Back-to-back loads
        txn(1'b0, 3'd2, 32'h00, 32'h0);
        txn(1'b0, 3'd2, 32'h04, 32'h0);
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            sz = $urandom_range(0, 7);
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz[1:0] == 2'd1) a[0] = 1'b0;
                else if (sz[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            txn(1'($urandom_range(0, 1)), 3'(sz), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        // No-stall store variant: store completes in one cycle, load follows immediately
        x = $urandom;
        $display("[TB] no-stall SW addr=00000008 data=%h then LW", x);
        req0 = 1'b1; we0 = 1'b1; size0 = 3'd2; addr0 = 32'h8; wdat0 = x;
        @(negedge clk);
        chk("ss0_st_stall", stall0, 0);
        chk("ss0_st_req", {dreq0, dwe0, dbe0, daddr0, dwdata0}, {1'b1, 1'b1, 4'hF, 32'h8, x});
        @(posedge clk);
        #1;
        we0 = 1'b0;
        @(negedge clk);
        chk("ss0_ld_req", {dreq0, dwe0, dbe0, daddr0}, {1'b1, 1'b0, 4'hF, 32'h8});
        chk("ss0_ld_stall", stall0, 1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("ss0_ld_data", ldata0, x);
        chk("ss0_wait_stall", stall0, 0);
        idle(1);

        chk("pending_reqs", exp_req_q.size(), 0);
        chk("pending_loads", exp_load_q.size(), 0);
        chk("pending_faults", exp_fault_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
